apb_multi_slave_mem: RTL and testbench
======================================

// Module: apb_multi_slave_mem
// PURPOSE
//  Parametrised APB4 completer emulating NO_OF_SLAVES independent word memories behind one-hot pselx.
//  Adds per-slave wait states, pstrb byte-lane writes, pprot privilege checking, address-window/gap
//  decode with pslverr, and a saturating error counter. Serves as the DUT-side slave model for the APB env.
// PARAMETERS
//  NO_OF_SLAVES    4   number of pselx lines / memory regions (1..16)
//  ADDRESS_WIDTH   32  paddr width
//  DATA_WIDTH      32  pwdata/prdata width (8,16,32); BYTES = DATA_WIDTH/8
//  MEM_DEPTH       16  words per slave region
//  GAP_WORDS       2   unmapped words between consecutive regions
//  WAIT_W          4   width of each per-slave wait-state field
//  PRIV_MASK       0   bit s=1: slave s requires pprot[0]=1 (privileged)
// PORTS
//  pclk          in   1                    APB clock
//  preset        in   1                    synchronous active-high reset
//  pselx         in   NO_OF_SLAVES         one-hot slave select
//  penable       in   1                    access phase
//  pwrite        in   1                    1=write 0=read
//  paddr         in   ADDRESS_WIDTH        byte address
//  pwdata        in   DATA_WIDTH           write data
//  pstrb         in   BYTES                write byte lanes
//  pprot         in   3                    protection type
//  wait_cfg      in   NO_OF_SLAVES*WAIT_W  field s = wait states for slave s
//  pready        out  1                    transfer complete
//  prdata        out  DATA_WIDTH           read data, valid when pready&&!pwrite
//  pslverr       out  1                    error, valid when pready
//  err_count     out  8                    saturating count of errored transfers
// BEHAVIOUR
//  Reset: state IDLE, pready=0, prdata=0, pslverr=0, err_count=0, all memory words=0; preset wins over any transfer.
//  Region s base = s*(MEM_DEPTH+GAP_WORDS)*BYTES; word idx = (paddr-base)/BYTES.
//  FSM IDLE -> SETUP when |pselx && !penable; all request inputs captured at that edge.
//  SETUP -> ACCESS next cycle; counter loaded with wait_cfg[s] (s = selected slave).
//  ACCESS: counter decrements each cycle; pready=1 combinationally when state==ACCESS && counter==0.
//   Latency = wait_cfg[s]+1 access cycles; W=0 gives zero-wait APB (pready in first access cycle).
//  On pready cycle: write commits bytes where pstrb[b]=1; read drives prdata from registered memory word.
//   prdata/pslverr are stable throughout pready cycle; back to IDLE, or SETUP if a new setup is presented.
//  Error (pslverr=1, no memory change, prdata=0) when any of:
//   pselx not one-hot; paddr[log2(BYTES)-1:0]!=0; paddr outside region window (incl. gap);
//   PRIV_MASK[s]=1 && pprot[0]=0; read with pstrb!=0.
//  Errors still honour the wait-state count; err_count increments on each errored pready, saturates at 255.
//  Write with pstrb=0: no memory change, no error.
//  psel or penable deasserted while in ACCESS before pready: abort to IDLE, no write, no error, no count.
//  Inputs changing during ACCESS are ignored (captured copy used); wait_cfg is sampled only at SETUP.
// TESTING
//  W=0, write 0xDEADBEEF to slave0 @0x0 pstrb=4'hF, then read -> pready in 1st access cycle, prdata=0xDEADBEEF.
//  wait_cfg[1]=3, read slave1 @0x48 (word0) -> pready exactly on 4th access cycle, prdata=0, pslverr=0.
//  Write 0x11223344 then pstrb=4'b0101 data 0xAABBCCDD to slave2 @0x90 -> readback 0x11BB33DD.
//  Slave0 @0x40 (gap) or @0x2 (misaligned) -> pslverr=1, err_count +1, memory unchanged.
//  PRIV_MASK=4'b1000, write slave3 pprot=3'b000 -> pslverr=1; same with pprot=3'b001 -> ok.
//  Drop psel mid-wait (W=5) on write -> FSM IDLE, word unchanged; preset mid-access -> all outputs 0.

Source files
------------

// File: rtl/apb_multi_slave_mem.sv
// APB4 completer that models NO_OF_SLAVES word memories behind a one-hot pselx.
// It adds per-slave wait states, byte strobes, privilege checks, window decode and a saturating error counter.
module apb_multi_slave_mem #(
  parameter int unsigned NO_OF_SLAVES  = 4,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_DEPTH     = 16,
  parameter int unsigned GAP_WORDS     = 2,
  parameter int unsigned WAIT_W        = 4,
  parameter logic [NO_OF_SLAVES-1:0] PRIV_MASK = '0
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic [NO_OF_SLAVES-1:0]          pselx,
  input  logic                             penable,
  input  logic                             pwrite,
  input  logic [ADDRESS_WIDTH-1:0]         paddr,
  input  logic [DATA_WIDTH-1:0]            pwdata,
  input  logic [DATA_WIDTH/8-1:0]          pstrb,
  input  logic [2:0]                       pprot,
  input  logic [NO_OF_SLAVES*WAIT_W-1:0]   wait_cfg,
  output logic                             pready,
  output logic [DATA_WIDTH-1:0]            prdata,
  output logic                             pslverr,
  output logic [7:0]                       err_count
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned BSH   = $clog2(BYTES);
  localparam int unsigned WORDS = NO_OF_SLAVES * MEM_DEPTH;
  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned SW    = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] REGION_B = ADDRESS_WIDTH'((MEM_DEPTH + GAP_WORDS) * BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] WIN_B    = ADDRESS_WIDTH'(MEM_DEPTH * BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_M  = ADDRESS_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                    r_state, w_next;
  logic [NO_OF_SLAVES-1:0]   r_sel;
  logic                      r_write;
  logic [ADDRESS_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [BYTES-1:0]          r_strb;
  logic                      r_priv;
  logic [WAIT_W-1:0]         r_cnt;
  logic [7:0]                r_err_cnt;
  logic [DATA_WIDTH-1:0]     r_mem [WORDS];

  logic [SW-1:0]             w_sidx;
  logic                      w_found;
  logic [WAIT_W-1:0]         w_wait;
  logic [ADDRESS_WIDTH-1:0]  w_base, w_off, w_word;
  logic [IW-1:0]             w_idx;
  logic                      w_onehot, w_in_win, w_misalign, w_priv_err, w_rd_strb, w_err;
  logic                      w_done, w_abort, w_new_setup, w_capture;

  // Lowest set select bit picks the region; a non-one-hot select errors anyway.
  always_comb begin
    w_sidx  = '0;
    w_found = 1'b0;
    w_wait  = '0;
    for (int unsigned i = 0; i < NO_OF_SLAVES; i++) begin
      if (r_sel[i] && !w_found) begin
        w_sidx  = SW'(i);
        w_found = 1'b1;
        w_wait  = wait_cfg[i*WAIT_W +: WAIT_W];
      end
    end
  end

  always_comb begin
    w_base     = ADDRESS_WIDTH'(w_sidx) * REGION_B;
    w_off      = r_addr - w_base;
    w_word     = w_off >> BSH;
    w_idx      = IW'(ADDRESS_WIDTH'(w_sidx) * ADDRESS_WIDTH'(MEM_DEPTH) + w_word);
    w_onehot   = (r_sel != '0) && ((r_sel & (r_sel - NO_OF_SLAVES'(1))) == '0);
    w_in_win   = (r_addr >= w_base) && (w_off < WIN_B);
    w_misalign = (r_addr & ALIGN_M) != '0;
    w_priv_err = PRIV_MASK[w_sidx] && !r_priv;
    w_rd_strb  = !r_write && (r_strb != '0);
    w_err      = !w_onehot || !w_in_win || w_misalign || w_priv_err || w_rd_strb;
  end

  assign w_done      = (r_state == ACCESS) && (r_cnt == '0);
  assign w_abort     = (r_state == ACCESS) && (r_cnt != '0) && !((|pselx) && penable);
  assign w_new_setup = (|pselx) && !penable;
  assign w_capture   = (w_next == SETUP);

  always_ff @(posedge pclk) begin
    if (preset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    case (r_state)
      IDLE:   if (w_new_setup) w_next = SETUP;
      SETUP:  w_next = ACCESS;
      ACCESS: begin
        if (w_done) begin
          pready  = 1'b1;
          pslverr = w_err;
          if (!r_write && !w_err) prdata = r_mem[w_idx];
          w_next  = w_new_setup ? SETUP : IDLE;
        end else if (w_abort) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_sel   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_priv  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_capture) begin
        r_sel   <= pselx;
        r_write <= pwrite;
        r_addr  <= paddr;
        r_wdata <= pwdata;
        r_strb  <= pstrb;
        r_priv  <= pprot[0];
      end
      if (r_state == SETUP)                    r_cnt <= w_wait;
      else if (r_state == ACCESS && r_cnt != '0) r_cnt <= r_cnt - WAIT_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset)                                 r_err_cnt <= '0;
    else if (w_done && w_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_count = r_err_cnt;

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int unsigned i = 0; i < WORDS; i++) r_mem[i] <= '0;
    end else if (w_done && r_write && !w_err) begin
      for (int unsigned b = 0; b < BYTES; b++)
        if (r_strb[b]) r_mem[w_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_apb_multi_slave_mem.sv
// Directed bench for apb_multi_slave_mem: 4 slaves, 32-bit data, regions 0x48 bytes apart, slave3 privileged.
// Cycle counts are penable cycles up to pready; the first is the SETUP state, so W waits give W+2.
module tb_apb_multi_slave_mem;

  logic        pclk = 1'b0;
  logic        preset;
  logic [3:0]  pselx;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [15:0] wait_cfg;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int exp_ec = 0;

  apb_multi_slave_mem #(
    .NO_OF_SLAVES(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16),
    .GAP_WORDS(2), .WAIT_W(4), .PRIV_MASK(4'b1000)
  ) dut (
    .pclk(pclk), .preset(preset), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .wait_cfg(wait_cfg),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .err_count(err_count)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic idle_bus();
    pselx = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; pprot = '0;
  endtask

  task automatic xfer(input logic [3:0] sel, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] prot,
                      output logic [31:0] rd, output logic err, output int cyc);
    logic done;
    cyc = 0; rd = '0; err = 1'b0; done = 1'b0;
    @(posedge pclk); #1;
    pselx = sel; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st; pprot = prot;
    @(posedge pclk); #1 penable = 1'b1;
    while (!done && cyc < 40) begin
      @(negedge pclk);
      cyc++;
      if (pready) begin rd = prdata; err = pslverr; done = 1'b1; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_timeout: no pready after %0d cycles, expected within 40", cyc);
    end
    @(posedge pclk); #1 idle_bus();
  endtask

  task automatic test_reset();
    preset = 1'b1; wait_cfg = '0; idle_bus();
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    checks++; if (pready !== 1'b0)   begin errors++; $display("FAIL rst_pready: got %b expected 0", pready); end
    checks++; if (prdata !== 32'h0)  begin errors++; $display("FAIL rst_prdata: got %h expected 0", prdata); end
    checks++; if (pslverr !== 1'b0)  begin errors++; $display("FAIL rst_pslverr: got %b expected 0", pslverr); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_errcnt: got %0d expected 0", err_count); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic err; int cyc;
    wait_cfg = 16'h0000;
    xfer(4'b0001, 1'b1, 32'h0, 32'hDEADBEEF, 4'hF, 3'b000, rd, err, cyc);
    checks++; if (cyc !== 2)   begin errors++; $display("FAIL zw_wr_cycles: got %0d expected 2", cyc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL zw_wr_err: got %b expected 0", err); end
    xfer(4'b0001, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL zw_rd_cycles: got %0d expected 2", cyc); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_rd_data: got %h expected deadbeef", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL zw_rd_err: got %b expected 0", err); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int cyc;
    wait_cfg = 16'h0030;
    xfer(4'b0010, 1'b0, 32'h48, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    checks++; if (cyc !== 5)   begin errors++; $display("FAIL ws_cycles: got %0d expected 5", cyc); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ws_rdata: got %h expected 0", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ws_err: got %b expected 0", err); end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic err; int cyc;
    wait_cfg = 16'h0000;
    xfer(4'b0100, 1'b1, 32'h90, 32'h11223344, 4'hF, 3'b000, rd, err, cyc);
    xfer(4'b0100, 1'b1, 32'h90, 32'hAABBCCDD, 4'b0101, 3'b000, rd, err, cyc);
    xfer(4'b0100, 1'b0, 32'h90, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strb_merge: got %h expected 11bb33dd", rd); end
    xfer(4'b0100, 1'b1, 32'h90, 32'hFFFFFFFF, 4'h0, 3'b000, rd, err, cyc);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL strb_zero_err: got %b expected 0", err); end
    xfer(4'b0100, 1'b0, 32'h90, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strb_zero_data: got %h expected 11bb33dd", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int cyc;
    wait_cfg = 16'h0000;
    xfer(4'b0001, 1'b1, 32'h40, 32'h55555555, 4'hF, 3'b000, rd, err, cyc); exp_ec++;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_gap: got %b expected 1", err); end
    xfer(4'b0001, 1'b1, 32'h2, 32'h55555555, 4'hF, 3'b000, rd, err, cyc); exp_ec++;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_misalign: got %b expected 1", err); end
    checks++; if (err_count !== 8'(exp_ec)) begin errors++; $display("FAIL err_cnt2: got %0d expected %0d", err_count, exp_ec); end
    xfer(4'b0001, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL err_mem_kept: got %h expected deadbeef", rd); end
    xfer(4'b0001, 1'b0, 32'h44, 32'h0, 4'h0, 3'b000, rd, err, cyc); exp_ec++;
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_gap_rd: got err=%b data=%h expected err=1 data=0", err, rd); end
    xfer(4'b0011, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, err, cyc); exp_ec++;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_not_onehot: got %b expected 1", err); end
    xfer(4'b0001, 1'b0, 32'h0, 32'h0, 4'hF, 3'b000, rd, err, cyc); exp_ec++;
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_rd_strb: got err=%b data=%h expected err=1 data=0", err, rd); end
    wait_cfg = 16'h0002;
    xfer(4'b0001, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, err, cyc); exp_ec++;
    checks++; if (cyc !== 4 || err !== 1'b1) begin errors++; $display("FAIL err_wait: got cyc=%0d err=%b expected cyc=4 err=1", cyc, err); end
    checks++; if (err_count !== 8'(exp_ec)) begin errors++; $display("FAIL err_cnt6: got %0d expected %0d", err_count, exp_ec); end
  endtask

  task automatic test_priv();
    logic [31:0] rd; logic err; int cyc;
    wait_cfg = 16'h0000;
    xfer(4'b1000, 1'b1, 32'hD8, 32'hCAFEF00D, 4'hF, 3'b000, rd, err, cyc); exp_ec++;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL priv_unpriv_wr: got %b expected 1", err); end
    xfer(4'b1000, 1'b0, 32'hD8, 32'h0, 4'h0, 3'b001, rd, err, cyc);
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL priv_unchanged: got err=%b data=%h expected err=0 data=0", err, rd); end
    xfer(4'b1000, 1'b1, 32'hD8, 32'h12345678, 4'hF, 3'b001, rd, err, cyc);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL priv_wr: got %b expected 0", err); end
    xfer(4'b1000, 1'b0, 32'hD8, 32'h0, 4'h0, 3'b001, rd, err, cyc);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL priv_rd: got %h expected 12345678", rd); end
    checks++; if (err_count !== 8'(exp_ec)) begin errors++; $display("FAIL priv_cnt: got %0d expected %0d", err_count, exp_ec); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int cyc; logic seen;
    wait_cfg = 16'h0035;
    seen = 1'b0;
    @(posedge pclk); #1;
    pselx = 4'b0001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h0BADF00D; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    repeat (3) begin @(negedge pclk); if (pready) seen = 1'b1; end
    idle_bus();
    repeat (2) begin @(negedge pclk); if (pready) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_pready: got %b expected 0", seen); end
    xfer(4'b0001, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL abort_rd_cycles: got %0d expected 7", cyc); end
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL abort_word: got data=%h err=%b expected 0/0", rd, err); end
    checks++; if (err_count !== 8'(exp_ec)) begin errors++; $display("FAIL abort_cnt: got %0d expected %0d", err_count, exp_ec); end
  endtask

  task automatic test_back_to_back();
    logic seen;
    wait_cfg = 16'h0000;
    seen = 1'b0;
    @(posedge pclk); #1;
    pselx = 4'b0001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    checks++; if (pready !== 1'b1 || pslverr !== 1'b0) begin errors++; $display("FAIL b2b_wr: got pready=%b pslverr=%b expected 1/0", pready, pslverr); end
    penable = 1'b0; pwrite = 1'b0; pstrb = '0; pwdata = '0;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk); if (pready) seen = 1'b1;
    @(negedge pclk);
    checks++; if (seen !== 1'b0 || pready !== 1'b1) begin errors++; $display("FAIL b2b_timing: got early=%b pready=%b expected 0/1", seen, pready); end
    checks++; if (prdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_rdata: got %h expected a5a5a5a5", prdata); end
    @(posedge pclk); #1 idle_bus();
  endtask

  task automatic test_saturation();
    logic [31:0] rd; logic err; int cyc;
    wait_cfg = 16'h0000;
    while (exp_ec < 258) begin
      xfer(4'b0001, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      exp_ec++;
    end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_cnt: got %0d expected 255", err_count); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc;
    wait_cfg = 16'h0035;
    @(posedge pclk); #1;
    pselx = 4'b0001; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8;
    @(posedge pclk); #1 penable = 1'b1;
    repeat (3) @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    checks++; if (pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_outs: got pready=%b prdata=%h pslverr=%b errcnt=%0d expected all 0", pready, prdata, pslverr, err_count);
    end
    idle_bus(); preset = 1'b0;
    xfer(4'b0001, 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    checks++; if (rd !== 32'h0 || cyc !== 7) begin errors++; $display("FAIL rstmid_mem: got data=%h cyc=%0d expected 0/7", rd, cyc); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_strobe();
    test_errors();
    test_priv();
    test_abort();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
